// File: rtl/change_dispenser.sv
// Greedy change payout: ejects quarter/dime/nickel pulses from finite stock,
// one coin per SELECT -> PULSE -> GAP round, and reports unpaid cents on failure.
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int STOCK_W      = 4,
  parameter int STOCK_Q      = 8,
  parameter int STOCK_D      = 8,
  parameter int STOCK_N      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] change_amt,
  input  logic       refill,
  output logic [2:0] coin_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] remaining,
  output logic [2:0] empty
);

  // state   | meaning
  // IDLE    | waiting for start; refill reloads stocks
  // SELECT  | pick largest affordable coin in stock, or finish
  // PULSE   | coin_out held for PULSE_CYCLES
  // GAP     | coin_out low for GAP_CYCLES
  // DONE    | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;

  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t             state, state_nxt;
  logic [2:0]         coin_nxt;
  logic [7:0]         rem_nxt;
  logic               err_nxt;
  logic [STOCK_W-1:0] stock_q, stock_d, stock_n;
  logic [STOCK_W-1:0] q_nxt, d_nxt, n_nxt;
  logic [TW-1:0]      timer, timer_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      coin_out  <= '0;
      remaining <= '0;
      error     <= 1'b0;
      stock_q   <= STOCK_W'(STOCK_Q);
      stock_d   <= STOCK_W'(STOCK_D);
      stock_n   <= STOCK_W'(STOCK_N);
      timer     <= '0;
    end else begin
      state     <= state_nxt;
      coin_out  <= coin_nxt;
      remaining <= rem_nxt;
      error     <= err_nxt;
      stock_q   <= q_nxt;
      stock_d   <= d_nxt;
      stock_n   <= n_nxt;
      timer     <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    coin_nxt  = coin_out;
    rem_nxt   = remaining;
    err_nxt   = error;
    q_nxt     = stock_q;
    d_nxt     = stock_d;
    n_nxt     = stock_n;
    timer_nxt = timer;
    case (state)
      S_IDLE: begin
        // refill is applied first so a simultaneous start pays from full stock
        if (refill) begin
          q_nxt = STOCK_W'(STOCK_Q);
          d_nxt = STOCK_W'(STOCK_D);
          n_nxt = STOCK_W'(STOCK_N);
        end
        if (start) begin
          rem_nxt   = change_amt;
          err_nxt   = 1'b0;
          state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        timer_nxt = TW'(PULSE_CYCLES - 1);
        if (remaining == 8'd0) begin
          err_nxt   = 1'b0;
          state_nxt = S_DONE;
        end else if (remaining >= 8'd25 && stock_q != '0) begin
          coin_nxt  = 3'b100;
          rem_nxt   = remaining - 8'd25;
          q_nxt     = stock_q - STOCK_W'(1);
          state_nxt = S_PULSE;
        end else if (remaining >= 8'd10 && stock_d != '0) begin
          coin_nxt  = 3'b010;
          rem_nxt   = remaining - 8'd10;
          d_nxt     = stock_d - STOCK_W'(1);
          state_nxt = S_PULSE;
        end else if (remaining >= 8'd5 && stock_n != '0) begin
          coin_nxt  = 3'b001;
          rem_nxt   = remaining - 8'd5;
          n_nxt     = stock_n - STOCK_W'(1);
          state_nxt = S_PULSE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_PULSE: begin
        if (timer == '0) begin
          coin_nxt  = 3'b000;
          timer_nxt = TW'(GAP_CYCLES - 1);
          state_nxt = S_GAP;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_GAP: begin
        if (timer == '0) state_nxt = S_SELECT;
        else             timer_nxt = timer - TW'(1);
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign empty = {stock_q == '0, stock_d == '0, stock_n == '0};

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed table of payouts, reset/noise corner
// cases, then random payouts compared with a greedy arithmetic model.
module tb_change_dispenser;
  localparam int P = 4;
  localparam int G = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       refill = 1'b0;
  logic [7:0] change_amt = 8'd0;
  logic [2:0] coin_out, empty;
  logic       busy, done, error;
  logic [7:0] remaining;

  change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G), .STOCK_W(4),
                     .STOCK_Q(8), .STOCK_D(8), .STOCK_N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .change_amt(change_amt),
    .refill(refill), .coin_out(coin_out), .busy(busy), .done(done),
    .error(error), .remaining(remaining), .empty(empty));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    int rf; int amt; int nq; int nd; int nn;
    int err; int rem; int sq; int sd; int sn; int emp;
  } vec_t;
  vec_t tbl[9];

  // Reference model state
  int mq, md, mn, m_err, m_rem;
  logic [2:0] exp_q[$];
  logic [2:0] got_q[$];

  task automatic model_payout(input int amt, input int rf);
    int r;
    r = amt;
    exp_q.delete();
    if (rf != 0) begin mq = 8; md = 8; mn = 8; end
    m_err = 0;
    while (r > 0) begin
      if (r >= 25 && mq > 0)      begin exp_q.push_back(3'b100); r -= 25; mq--; end
      else if (r >= 10 && md > 0) begin exp_q.push_back(3'b010); r -= 10; md--; end
      else if (r >= 5 && mn > 0)  begin exp_q.push_back(3'b001); r -= 5;  mn--; end
      else begin m_err = 1; break; end
    end
    m_rem = r;
  endtask

  // Drives one payout and records ejected coins; checks pulse/gap/done timing.
  task automatic run_payout(input logic [7:0] amt, input bit rf, input bit noise);
    int cyc, run, last_fall, exp_rise, exp_done, done_cyc, bad;
    bit done_seen;
    logic [2:0] prev;
    got_q.delete();
    bad = 0; done_seen = 0; done_cyc = 0;
    @(negedge clk); start = 1'b1; change_amt = amt; refill = rf;
    @(negedge clk); start = 1'b0; refill = 1'b0; change_amt = 8'($urandom);
    cyc = 0; run = 0; prev = 3'b000; last_fall = 0;
    while (!done_seen && cyc < 400) begin
      cyc++;
      if (noise && cyc == 6) begin start = 1'b1; refill = 1'b1; change_amt = 8'($urandom); end
      else if (noise && cyc == 7) begin start = 1'b0; refill = 1'b0; end
      if (busy !== 1'b1) bad++;
      if ($countones(coin_out) > 1) bad++;
      if (coin_out !== 3'b000) begin
        if (prev === 3'b000) begin
          got_q.push_back(coin_out);
          exp_rise = (got_q.size() == 1) ? 2 : last_fall + G + 1;
          if (cyc != exp_rise) bad++;
          run = 0;
        end else if (coin_out !== prev) bad++;
        run++;
      end else if (prev !== 3'b000) begin
        if (run != P) bad++;
        last_fall = cyc;
      end
      prev = coin_out;
      if (done === 1'b1) begin done_seen = 1; done_cyc = cyc; end
      else @(negedge clk);
    end
    start = 1'b0; refill = 1'b0;
    check("done_seen", 32'(done_seen), 1);
    exp_done = (got_q.size() == 0) ? 2 : last_fall + G + 1;
    check("done_latency", done_cyc, exp_done);
    check("pulse_timing", bad, 0);
    @(negedge clk);
    check("idle_after_done", {busy, done}, 0);
  endtask

  initial begin
    int nq, nd, nn, order_bad, n, cyc, rf, amt;
    logic [2:0] prev;

    tbl[0] = '{0, 40,  1, 1, 1, 0, 0, 7, 7, 7, 0};
    tbl[1] = '{0, 0,   0, 0, 0, 0, 0, 7, 7, 7, 0};
    tbl[2] = '{0, 7,   0, 0, 1, 1, 2, 7, 7, 6, 0};
    tbl[3] = '{0, 175, 7, 0, 0, 0, 0, 0, 7, 6, 4};
    tbl[4] = '{0, 30,  0, 3, 0, 0, 0, 0, 4, 6, 4};
    tbl[5] = '{0, 40,  0, 4, 0, 0, 0, 0, 0, 6, 6};
    tbl[6] = '{0, 30,  0, 0, 6, 0, 0, 0, 0, 0, 7};
    tbl[7] = '{0, 5,   0, 0, 0, 1, 5, 0, 0, 0, 7};
    tbl[8] = '{1, 65,  2, 1, 1, 0, 0, 6, 7, 7, 0};

    #12;
    check("rst_coin_out", coin_out, 0);
    check("rst_busy_done_err", {busy, done, error}, 0);
    check("rst_remaining", remaining, 0);
    check("rst_empty", empty, 0);
    check("rst_stocks", {dut.stock_q, dut.stock_d, dut.stock_n}, {4'd8, 4'd8, 4'd8});
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      repeat (3) @(negedge clk);
      if (i > 0) check("err_held", error, tbl[i-1].err);
      run_payout(8'(tbl[i].amt), tbl[i].rf[0], 1'b0);
      nq = 0; nd = 0; nn = 0; order_bad = 0;
      for (int k = 0; k < got_q.size(); k++) begin
        if (got_q[k] == 3'b100) nq++;
        else if (got_q[k] == 3'b010) nd++;
        else if (got_q[k] == 3'b001) nn++;
        if (k > 0 && got_q[k] > got_q[k-1]) order_bad++;
      end
      check($sformatf("tbl%0d_coins", i), {8'(nq), 8'(nd), 8'(nn)},
            {8'(tbl[i].nq), 8'(tbl[i].nd), 8'(tbl[i].nn)});
      check($sformatf("tbl%0d_order", i), order_bad, 0);
      check($sformatf("tbl%0d_error", i), error, tbl[i].err);
      check($sformatf("tbl%0d_remaining", i), remaining, tbl[i].rem);
      check($sformatf("tbl%0d_stocks", i), {dut.stock_q, dut.stock_d, dut.stock_n},
            {4'(tbl[i].sq), 4'(tbl[i].sd), 4'(tbl[i].sn)});
      check($sformatf("tbl%0d_empty", i), empty, tbl[i].emp);
    end

    // Refill alone in IDLE
    @(negedge clk); refill = 1'b1;
    @(negedge clk); refill = 1'b0;
    check("refill_stocks", {dut.stock_q, dut.stock_d, dut.stock_n}, {4'd8, 4'd8, 4'd8});
    check("refill_busy", busy, 0);

    // Reset during the second coin pulse
    @(negedge clk); start = 1'b1; change_amt = 8'd40;
    @(negedge clk); start = 1'b0;
    n = 0; cyc = 0; prev = 3'b000;
    while (n < 2 && cyc < 100) begin
      if (coin_out !== 3'b000 && prev === 3'b000) n++;
      prev = coin_out;
      if (n < 2) begin @(negedge clk); cyc++; end
    end
    check("reach_pulse2", n, 2);
    check("pulse2_is_dime", coin_out, 3'b010);
    #1 reset = 1'b0;
    #1;
    check("midrst_coin_out", coin_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_remaining", remaining, 0);
    check("midrst_stocks", {dut.stock_q, dut.stock_d, dut.stock_n}, {4'd8, 4'd8, 4'd8});
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    // Random payouts against the greedy model
    mq = 8; md = 8; mn = 8; m_err = 0;
    for (int t = 0; t < 30; t++) begin
      rf  = ($urandom_range(0, 9) < 3) ? 1 : 0;
      amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 80));
      check("rnd_err_held", error, m_err);
      model_payout(amt, rf);
      run_payout(8'(amt), rf[0], 1'($urandom_range(0, 1)));
      n = 0;
      if (got_q.size() != exp_q.size()) n++;
      else for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== exp_q[k]) n++;
      check($sformatf("rnd%0d_seq amt=%0d", t, amt), n, 0);
      check($sformatf("rnd%0d_error", t), error, m_err);
      check($sformatf("rnd%0d_remaining", t), remaining, m_rem);
      check($sformatf("rnd%0d_stocks", t), {dut.stock_q, dut.stock_d, dut.stock_n},
            {4'(mq), 4'(md), 4'(mn)});
      check($sformatf("rnd%0d_empty", t), empty, {mq == 0, md == 0, mn == 0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
